// File: rtl/profile_pkg.sv
// profile_pkg: shared constants and helpers for the profile counter bank.
//   - SPSR offset constants and offset helpers derived from the counter count
//   - control/overflow register bit positions
//   - parameter legality check used at elaboration
package profile_pkg;

  localparam int unsigned OFF_CTRL  = 0;
  localparam int unsigned OFF_OVF   = 1;
  localparam int unsigned OFF_MASK0 = 2;
  localparam int unsigned OFF_CMP0  = 64;
  localparam int unsigned OFF_HITS  = 80;

  localparam int unsigned CTRL_ENABLE_BIT  = 9;
  localparam int unsigned CTRL_PAUSE_BIT   = 10;
  localparam int unsigned CTRL_IRQEN_BIT   = 12;
  localparam int unsigned CTRL_PACTIVE_BIT = 16;

  localparam int unsigned OVF_CYCLE_BIT = 16;
  localparam int unsigned OVF_PROF_BIT  = 17;
  localparam int unsigned OVF_WIDTH     = 18;

  function automatic int unsigned off_cycle_lo(input int unsigned n);
    return OFF_MASK0 + n;
  endfunction

  function automatic int unsigned off_cnt_lo(input int unsigned n, input int unsigned idx);
    return 4 + n + 2 * idx;
  endfunction

  function automatic int unsigned off_prof_lo(input int unsigned n);
    return 4 + 3 * n;
  endfunction

  // Slice s: 0..n-1 event counters, n cycle counter, n+1 profile counter.
  function automatic int unsigned slice_lo_off(input int unsigned n, input int unsigned s);
    if (s < n)       return off_cnt_lo(n, s);
    else if (s == n) return off_cycle_lo(n);
    else             return off_prof_lo(n);
  endfunction

  function automatic bit params_legal(input int unsigned n, input int unsigned cw,
                                      input int unsigned ne, input logic [15:0] base);
    return (n >= 1) && (n <= 16) && (cw >= 33) && (cw <= 64) &&
           (ne >= 1) && (ne <= 32) && (base[6:0] == 7'd0);
  endfunction

endpackage

// File: rtl/profile_counter_slice.sv
// profile_counter_slice: one COUNTER_WIDTH wrapping counter.
//   clock, reset : system clock, synchronous active-high reset
//   rst_cnt      : synchronous clear, has priority over inc
//   inc          : increment by one this cycle
//   value        : current count
//   wrap         : high in the cycle an increment wraps all-ones to zero
module profile_counter_slice #(
  parameter int unsigned COUNTER_WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     rst_cnt,
  input  logic                     inc,
  output logic [COUNTER_WIDTH-1:0] value,
  output logic                     wrap
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rst_cnt)  cnt_d = '0;
    else if (inc) cnt_d = cnt_q + COUNTER_WIDTH'(1);
  end

  assign wrap  = inc & ~rst_cnt & (&cnt_q);
  assign value = cnt_q;

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/profile_counter_bank.sv
// profile_counter_bank: SPSR-mapped profiling counters for the or1300 core.
//   clock/reset      : system clock, synchronous active-high reset
//   stall            : blocks SPSR writes and shadow capture (counting continues)
//   weSpsr/spsrWriteIndex/dataFromCore : SPSR write port
//   reSpsr/spsrReadIndex/dataToCore    : SPSR read port (combinational data)
//   profilingActive  : debug-side request, reflected in control bit 16
//   events           : packed CPU event vector
//   profileIrq       : registered overflow (and threshold) interrupt
// Optional macro PROFILE_THRESHOLD_IRQ_EN adds per-counter compare registers
// and sticky threshold-hit flags.
module profile_counter_bank
  import profile_pkg::*;
#(
  parameter int unsigned NR_OF_COUNTERS = 8,
  parameter int unsigned COUNTER_WIDTH  = 64,
  parameter int unsigned NR_OF_EVENTS   = 32,
  parameter logic [15:0] BASE_INDEX     = 16'hF800
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    weSpsr,
  input  logic [15:0]             spsrWriteIndex,
  input  logic [31:0]             dataFromCore,
  input  logic                    reSpsr,
  input  logic [15:0]             spsrReadIndex,
  input  logic                    profilingActive,
  input  logic [NR_OF_EVENTS-1:0] events,
  output logic [31:0]             dataToCore,
  output logic                    profileIrq
);

  localparam int unsigned N  = NR_OF_COUNTERS;
  localparam int unsigned NS = N + 2;
  localparam int unsigned SW = COUNTER_WIDTH - 32;

  if (!params_legal(NR_OF_COUNTERS, COUNTER_WIDTH, NR_OF_EVENTS, BASE_INDEX)) begin : g_bad_params
    $error("profile_counter_bank: illegal parameter combination");
  end

  logic                    wr_hit, rd_hit, wr_acc, ctrl_wr, ovf_wr;
  logic [31:0]             wr_off, rd_off;
  logic                    enable_q, pause_q, irqen_q, pact_q, rstcnt_q, irq_q, irq_d;
  logic [OVF_WIDTH-1:0]    ovf_q, ovf_d, ovf_set;
  logic [NR_OF_EVENTS-1:0] mask_q [N];
  logic [SW-1:0]           shadow_q, shadow_d, lo_high;
  logic                    lo_sel;
  logic [NS-1:0]           inc, wrap;
  logic [COUNTER_WIDTH-1:0] cnt_val [NS];
  logic [31:0]             rd_data;
  logic                    unused_data;

  assign unused_data = ^dataFromCore;

  assign wr_hit  = spsrWriteIndex[15:7] == BASE_INDEX[15:7];
  assign rd_hit  = spsrReadIndex[15:7]  == BASE_INDEX[15:7];
  assign wr_off  = 32'(spsrWriteIndex[6:0]);
  assign rd_off  = 32'(spsrReadIndex[6:0]);
  assign wr_acc  = wr_hit & weSpsr & ~stall;
  assign ctrl_wr = wr_acc & (wr_off == OFF_CTRL);
  assign ovf_wr  = wr_acc & (wr_off == OFF_OVF);

  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < N; i++)
      inc[i] = enable_q & ~pause_q & (|(mask_q[i] & events));
    inc[N]   = enable_q & ~pause_q;
    inc[N+1] = enable_q;
  end

  for (genvar g = 0; g < NS; g++) begin : g_slice
    profile_counter_slice #(.COUNTER_WIDTH(COUNTER_WIDTH)) u_slice (
      .clock   (clock),
      .reset   (reset),
      .rst_cnt (rstcnt_q),
      .inc     (inc[g]),
      .value   (cnt_val[g]),
      .wrap    (wrap[g])
    );
  end

  always_comb begin
    ovf_set = '0;
    for (int unsigned i = 0; i < N; i++) ovf_set[i] = wrap[i];
    ovf_set[OVF_CYCLE_BIT] = wrap[N];
    ovf_set[OVF_PROF_BIT]  = wrap[N+1];
    // Set is OR-ed after the W1C mask so a same-cycle wrap survives the clear.
    if (rstcnt_q) ovf_d = '0;
    else          ovf_d = (ovf_q & ~(ovf_wr ? dataFromCore[OVF_WIDTH-1:0] : '0)) | ovf_set;
  end

`ifdef PROFILE_THRESHOLD_IRQ_EN
  logic [31:0]  cmp_q [N];
  logic [N-1:0] hits_q, hits_d, hit_set;
  logic         hits_wr;

  assign hits_wr = wr_acc & (wr_off == OFF_HITS);

  always_comb begin
    hit_set = '0;
    for (int unsigned i = 0; i < N; i++)
      hit_set[i] = inc[i] & ~rstcnt_q & ((cnt_val[i][31:0] + 32'd1) == cmp_q[i]);
    // Hit flags are cleared together with the counters they refer to.
    if (rstcnt_q) hits_d = '0;
    else          hits_d = (hits_q & ~(hits_wr ? dataFromCore[N-1:0] : '0)) | hit_set;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hits_q <= '0;
      for (int unsigned i = 0; i < N; i++) cmp_q[i] <= '0;
    end else begin
      hits_q <= hits_d;
      for (int unsigned i = 0; i < N; i++)
        if (wr_acc & ~enable_q & (wr_off == OFF_CMP0 + i)) cmp_q[i] <= dataFromCore;
    end
  end

  assign irq_d = irqen_q & ((|ovf_q) | (|hits_q));
`else
  assign irq_d = irqen_q & (|ovf_q);
`endif

  always_comb begin
    rd_data = '0;
    lo_sel  = 1'b0;
    lo_high = '0;
    if (rd_hit) begin
      if (rd_off == OFF_CTRL) begin
        rd_data[CTRL_PACTIVE_BIT] = pact_q;
        rd_data[CTRL_IRQEN_BIT]   = irqen_q;
        rd_data[CTRL_PAUSE_BIT]   = pause_q;
        rd_data[CTRL_ENABLE_BIT]  = enable_q;
        rd_data[4:0]              = 5'(N);
      end
      if (rd_off == OFF_OVF) rd_data = 32'(ovf_q);
      for (int unsigned i = 0; i < N; i++)
        if (rd_off == OFF_MASK0 + i) rd_data = 32'(mask_q[i]);
      for (int unsigned s = 0; s < NS; s++) begin
        if (rd_off == slice_lo_off(N, s)) begin
          rd_data = cnt_val[s][31:0];
          lo_sel  = 1'b1;
          lo_high = cnt_val[s][COUNTER_WIDTH-1:32];
        end
        if (rd_off == slice_lo_off(N, s) + 1) rd_data = 32'(shadow_q);
      end
`ifdef PROFILE_THRESHOLD_IRQ_EN
      for (int unsigned i = 0; i < N; i++)
        if (rd_off == OFF_CMP0 + i) rd_data = cmp_q[i];
      if (rd_off == OFF_HITS) rd_data = 32'(hits_q);
`endif
    end
  end

  assign dataToCore = rd_data;

  always_comb begin
    shadow_d = shadow_q;
    if (rstcnt_q)                      shadow_d = '0;
    else if (reSpsr & ~stall & lo_sel) shadow_d = lo_high;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enable_q <= 1'b0;
      pause_q  <= 1'b0;
      irqen_q  <= 1'b0;
      pact_q   <= 1'b0;
      rstcnt_q <= 1'b1;
      irq_q    <= 1'b0;
      ovf_q    <= '0;
      shadow_q <= '0;
      for (int unsigned i = 0; i < N; i++) mask_q[i] <= '0;
    end else begin
      pact_q   <= profilingActive;
      rstcnt_q <= ctrl_wr & dataFromCore[CTRL_ENABLE_BIT] & ~enable_q;
      irq_q    <= irq_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      if (ctrl_wr) begin
        enable_q <= dataFromCore[CTRL_ENABLE_BIT];
        pause_q  <= dataFromCore[CTRL_PAUSE_BIT];
        irqen_q  <= dataFromCore[CTRL_IRQEN_BIT];
      end
      for (int unsigned i = 0; i < N; i++)
        if (wr_acc & ~enable_q & (wr_off == OFF_MASK0 + i))
          mask_q[i] <= dataFromCore[NR_OF_EVENTS-1:0];
    end
  end

  assign profileIrq = irq_q;

endmodule

// File: tb/tb_profile_counter_bank.sv
// tb_profile_counter_bank: directed self-checking bench for profile_counter_bank
// (N=12, COUNTER_WIDTH=40, BASE_INDEX=16'hF880).
module tb_profile_counter_bank;

  logic        clock, reset, stall, weSpsr, reSpsr, profilingActive;
  logic [15:0] spsrWriteIndex, spsrReadIndex;
  logic [31:0] dataFromCore, dataToCore, events;
  logic        profileIrq;
  logic [31:0] rdv;
  int          checks, failures;

  localparam logic [15:0] A_CTRL = 16'hF880;
  localparam logic [15:0] A_OVF  = 16'hF881;
  localparam logic [15:0] A_M0   = 16'hF882;
  localparam logic [15:0] A_M1   = 16'hF883;
  localparam logic [15:0] A_CYLO = 16'hF88E;
  localparam logic [15:0] A_C0LO = 16'hF890;
  localparam logic [15:0] A_C0HI = 16'hF891;
  localparam logic [15:0] A_C1LO = 16'hF892;
  localparam logic [15:0] A_C2LO = 16'hF894;
  localparam logic [15:0] A_PRLO = 16'hF8A8;
  localparam logic [15:0] A_CMP0 = 16'hF8C0;
  localparam logic [15:0] A_HITS = 16'hF8D0;

  profile_counter_bank #(
    .NR_OF_COUNTERS (12),
    .COUNTER_WIDTH  (40),
    .NR_OF_EVENTS   (32),
    .BASE_INDEX     (16'hF880)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .weSpsr          (weSpsr),
    .spsrWriteIndex  (spsrWriteIndex),
    .dataFromCore    (dataFromCore),
    .reSpsr          (reSpsr),
    .spsrReadIndex   (spsrReadIndex),
    .profilingActive (profilingActive),
    .events          (events),
    .dataToCore      (dataToCore),
    .profileIrq      (profileIrq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wr(input logic [15:0] idx, input logic [31:0] d);
    spsrWriteIndex = idx;
    dataFromCore   = d;
    weSpsr         = 1'b1;
    tick();
    weSpsr         = 1'b0;
  endtask

  // Samples the combinational read data, then lets one edge pass with reSpsr high.
  task automatic rd_chk(input string tag, input logic [15:0] idx, input logic [31:0] exp);
    spsrReadIndex = idx;
    reSpsr        = 1'b1;
    #1;
    rdv = dataToCore;
    check(tag, rdv, exp);
    tick();
    reSpsr = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] ev);
    events = ev;
    tick();
    events = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; stall = 1'b0; weSpsr = 1'b0; reSpsr = 1'b0;
    profilingActive = 1'b0; events = '0;
    spsrWriteIndex = '0; spsrReadIndex = '0; dataFromCore = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_irq", {31'd0, profileIrq}, 32'd0);
    rd_chk("reset_ctrl", A_CTRL, 32'h0000_000C);
    rd_chk("reset_ovf", A_OVF, 32'd0);
    rd_chk("reset_cnt0", A_C0LO, 32'd0);
    rd_chk("outside_base", 16'hF800, 32'd0);

    profilingActive = 1'b1;
    wr(A_M0, 32'h1);
    wr(A_M1, 32'h6);
    rd_chk("mask0_rb", A_M0, 32'h1);

    wr(A_CTRL, 32'h1200);   // enable + irqEnable; rstCnt fires next edge
    tick();
    pulse(32'h1); pulse(32'h5); pulse(32'h1); pulse(32'h5); pulse(32'h1);
    wr(A_CTRL, 32'h1600);   // pause
    pulse(32'h1); pulse(32'h1); pulse(32'h1);
    rd_chk("prof_lo", A_PRLO, 32'd9);
    rd_chk("cnt0_lo", A_C0LO, 32'd5);
    rd_chk("cnt1_lo", A_C1LO, 32'd2);
    rd_chk("cnt2_lo", A_C2LO, 32'd0);
    rd_chk("cycle_lo", A_CYLO, 32'd6);
    rd_chk("ctrl_paused", A_CTRL, 32'h0001_160C);

    wr(A_M0, 32'hFF);
    rd_chk("mask_locked", A_M0, 32'h1);

    // Overflow and interrupt timing.
    wr(A_CTRL, 32'h1200);
    force dut.g_slice[0].u_slice.cnt_q = 40'hFF_FFFF_FFFF;
    #1;
    release dut.g_slice[0].u_slice.cnt_q;
    pulse(32'h1);
    #1;
    check("irq_not_yet", {31'd0, profileIrq}, 32'd0);
    rd_chk("ovf_set", A_OVF, 32'h1);
    check("irq_set", {31'd0, profileIrq}, 32'd1);
    rd_chk("cnt0_wrapped", A_C0LO, 32'd0);
    wr(A_OVF, 32'h1);
    rd_chk("ovf_cleared", A_OVF, 32'd0);
    check("irq_cleared", {31'd0, profileIrq}, 32'd0);

    // Same-cycle set and clear.
    force dut.g_slice[0].u_slice.cnt_q = 40'hFF_FFFF_FFFF;
    #1;
    release dut.g_slice[0].u_slice.cnt_q;
    events = 32'h1;
    wr(A_OVF, 32'h1);
    events = '0;
    rd_chk("ovf_set_wins", A_OVF, 32'h1);
    wr(A_OVF, 32'h1);

    // Atomic high-word read through the shadow.
    force dut.g_slice[0].u_slice.cnt_q = 40'h01_FFFF_FFFF;
    #1;
    release dut.g_slice[0].u_slice.cnt_q;
    rd_chk("atomic_lo", A_C0LO, 32'hFFFF_FFFF);
    pulse(32'h1);
    rd_chk("atomic_hi", A_C0HI, 32'h1);
    rd_chk("live_lo", A_C0LO, 32'h0);
    rd_chk("fresh_hi", A_C0HI, 32'h2);

    stall = 1'b1;
    wr(A_CTRL, 32'h0);
    stall = 1'b0;
    rd_chk("stall_blocks_wr", A_CTRL, 32'h0001_120C);

    // Threshold compare (feature-dependent expectations).
    wr(A_CTRL, 32'h0);
    wr(A_CMP0, 32'd10);
`ifdef PROFILE_THRESHOLD_IRQ_EN
    rd_chk("cmp0_rb", A_CMP0, 32'd10);
`else
    rd_chk("cmp0_absent", A_CMP0, 32'd0);
`endif
    wr(A_CTRL, 32'h1200);
    tick();
    for (int i = 0; i < 9; i++) pulse(32'h1);
    rd_chk("hits_before", A_HITS, 32'd0);
    pulse(32'h1);
    rd_chk("cnt0_ten", A_C0LO, 32'd10);
`ifdef PROFILE_THRESHOLD_IRQ_EN
    rd_chk("hits_after", A_HITS, 32'd1);
`else
    rd_chk("hits_absent", A_HITS, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/profile_counter_bank.md
Name: profile_counter_bank

Overview:
Parametrised next-generation profiling block for the or1300 core. It provides NR_OF_COUNTERS event counters, each with a 32-bit event mask, plus a cycle counter and a free-running profile counter. It adds three things to the fixed 8-counter design: sticky overflow flags with an interrupt, atomic low/high word reads through a shadow register, and a configurable SPSR base index. It sits on the core's SPSR read/write path and consumes the packed CPU event vector.

Parameters:
NR_OF_COUNTERS, 8, number of masked event counters; legal range 1..16.
COUNTER_WIDTH, 64, width of every counter; legal range 33..64; high word is zero-extended.
NR_OF_EVENTS, 32, width of the events vector; legal range 1..32; masks use bits [NR_OF_EVENTS-1:0].
BASE_INDEX, 16'hF800, SPSR index of offset 0; must have bits [6:0] = 0.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
stall  in  1  core stall; blocks writes and shadow capture
weSpsr  in  1  SPSR write enable
spsrWriteIndex  in  16  SPSR write index
dataFromCore  in  32  write data
reSpsr  in  1  SPSR read strobe; used only for shadow capture
spsrReadIndex  in  16  SPSR read index
profilingActive  in  1  profiling request from the debug side
events  in  NR_OF_EVENTS  CPU event vector, one pulse per cycle per event
dataToCore  out  32  combinational read data
profileIrq  out  1  registered interrupt request

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high on clock. After reset, every register is 0, except rstCnt, which is 1.
- Address decode: hit when index[15:7] == BASE_INDEX[15:7]; off = index[6:0]. A write is accepted when hit & weSpsr & ~stall.
- Register map (off):
  - 0: control/status.
  - 1: overflow status.
  - 2..1+N: masks.
  - 2+N / 3+N: cycle counter low / high.
  - 4+N+2n / 5+N+2n: counter n low / high.
  - 4+3N / 5+3N: profile counter low / high.
  - All other offsets read 0.
- Control write fields: bit9 enable, bit10 pause, bit12 irqEnable.
- Control read fields: bit16 registered profilingActive, bit12 irqEnable, bit10 pause, bit9 enable, bits[4:0] NR_OF_COUNTERS.
- rstCnt: registered. It is set the cycle after an accepted control write with bit9=1 while enable=0. It clears all counters, overflow flags and the shadow.
- Mask writes are accepted only while enable=0; writes while enabled are ignored.
- Counter n: increments by 1 when enable & ~pause & |(mask[n] & events).
- Cycle counter: increments when enable & ~pause.
- Profile counter: increments when enable, ignoring pause.
- rstCnt has priority over increment.
- Wrap: at all-ones, the next increment gives 0 and sets the sticky overflow flag in the same cycle.
- Overflow status bits: [N-1:0] counters, 16 cycle counter, 17 profile counter.
- Overflow status is write-1-to-clear. If a set and a clear hit the same bit in one cycle, the set wins.
- profileIrq is registered: irqEnable & |overflow, one cycle after the flag sets.
- Atomic read: when reSpsr & ~stall & hit and off selects a low word, the matching counter's bits [COUNTER_WIDTH-1:32] are captured into the shadow at the clock edge.
- Low-word reads return the live value. High-word reads return the shadow. A high read with no preceding low read returns the last captured value (stale by design).
- Counters keep counting during stall.

Optional Feature:
- Macro: PROFILE_THRESHOLD_IRQ_EN.
- With the macro:
  - off 64+n: 32-bit compare register n, writable only while disabled.
  - off 80: sticky threshold-hit flags [N-1:0], write-1-to-clear.
  - A flag sets when counter n increments so that its low 32 bits equal compare n.
  - profileIrq = irqEnable & (|overflow | |hits).
- Without the macro: offsets 64..80 read 0, writes there are ignored, and no compare logic exists.

Decomposition:
- Shared package profile_pkg:
  - Offset constants and functions: OFF_CTRL=0, OFF_OVF=1, OFF_MASK0=2, and functions giving the cycle, counter and profile offsets from N.
  - Control bit positions.
  - Legal-range checks for the parameters.
- One sub-module, profile_counter_slice: a COUNTER_WIDTH counter with rstCnt, increment enable and an overflow-set output, instanced N+2 times.

Test Plan:
- Set mask0=32'h1 while disabled, then enable. Pulse events[0] 5 times, pause, pulse 3 more -> counter0 low=5, cycle counter stopped, profile counter still running.
- Write a mask while enabled -> mask reads back unchanged.
- Preset counter0 near all-ones (COUNTER_WIDTH=40), then one event -> counter reads 0, ovf bit0=1, profileIrq=1 one cycle later with irqEnable=1. Write 1 to ovf bit0 -> bit clears and irq drops.
- Set and clear the same overflow bit in one cycle -> bit stays 1.
- Atomic read: counter0 = 0x1_FFFF_FFFF, read low, then an event makes it 0x2_0000_0000, then read high -> low reads 0xFFFFFFFF, high reads 1.
- BASE_INDEX=16'hF880, N=12 -> off 0 bits[4:0]=12, index 16'hF800 reads 0. With PROFILE_THRESHOLD_IRQ_EN, set compare0=10 -> hit bit0 sets on the 10th event.
